// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Wait-stated data-memory slave for an RV32I load/store unit. A request is
// accepted in IDLE, held for WAIT_CYCLES extra cycles in WAIT, and the memory
// access happens on the edge that moves the FSM into RESP. The response stays
// on the bus until the initiator takes it, then the block returns to IDLE.
//
// Parameters
//   BUS_WIDTH    data/address width (32 for RV32I; at least 32)
//   DEPTH_WORDS  number of 32-bit memory words
//   WAIT_CYCLES  extra wait states per access, 0..15
//
// Ports
//   clk          clock, all state changes on its rising edge
//   rst          asynchronous, active-low reset
//   req_valid    initiator presents a load/store request
//   req_ready    high only in IDLE
//   req_we       1 = store, 0 = load
//   req_funct3   RV32I size/sign code
//   req_addr     byte address
//   req_wdata    store data, right-aligned
//   resp_valid   response available (RESP state)
//   resp_ready   initiator accepts the response
//   resp_rdata   load result extended to 32 bits, 0 for stores and errors
//   resp_err     request rejected (illegal code, misaligned, out of range)
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int BUS_WIDTH   = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [BUS_WIDTH-1:0] resp_rdata,
  output logic                 resp_err
);

  localparam int IDX_W  = BUS_WIDTH - 2;
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  // RV32I funct3 encodings for loads/stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State and latched request
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [BUS_WIDTH-1:0]  addr_q;
  logic [31:0]           wdata_q;

  logic                  accept;
  logic                  mem_we;

  // Memory array: 32-bit words, byte lanes merged by read-modify-write.
  logic [31:0]           mem [DEPTH_WORDS];

  // ---------------------------------------------------------------------------
  // Decode of the latched request
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]      word_idx;
  logic [MEM_AW-1:0]     mem_idx;
  logic                  funct3_ok;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  access_err;
  logic [31:0]           mem_word;
  logic [7:0]            byte_val;
  logic [15:0]           half_val;
  logic [31:0]           load_word;
  logic [31:0]           store_word;

  assign word_idx = addr_q[BUS_WIDTH-1:2];
  assign mem_idx  = addr_q[MEM_AW+1:2];
  assign mem_word = mem[mem_idx];

  // Stores only know B/H/W; loads add the unsigned B/H variants.
  assign funct3_ok = we_q ? (funct3_q inside {F3_B, F3_H, F3_W})
                          : (funct3_q inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

  // funct3[1:0] carries the access size for every legal code.
  always_comb begin
    misaligned = 1'b0;
    case (funct3_q[1:0])
      2'b01:   misaligned = addr_q[0];
      2'b10:   misaligned = (addr_q[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign out_of_range = (word_idx >= IDX_W'(DEPTH_WORDS));
  assign access_err   = !funct3_ok || misaligned || out_of_range;

  // Lane extraction for loads.
  assign byte_val = mem_word[{addr_q[1:0], 3'b000} +: 8];
  assign half_val = mem_word[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_word = 32'h0;
    case (funct3_q)
      F3_B:    load_word = {{24{byte_val[7]}}, byte_val};
      F3_H:    load_word = {{16{half_val[15]}}, half_val};
      F3_W:    load_word = mem_word;
      F3_BU:   load_word = {24'h0, byte_val};
      F3_HU:   load_word = {16'h0, half_val};
      default: load_word = 32'h0;
    endcase
  end

  // Lane merge for stores: untouched lanes keep the current word contents.
  always_comb begin
    store_word = mem_word;
    case (funct3_q[1:0])
      2'b00:   store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: store_word = wdata_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM next-state / datapath
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    accept  = 1'b0;
    mem_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Access happens on this edge; rejected requests never touch memory.
          state_d = RESP;
          err_d   = access_err;
          rdata_d = (we_q || access_err) ? 32'h0 : load_word;
          mem_we  = we_q && !access_err;
        end
      end

      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request capture; inputs outside IDLE never reach these registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
    end else if (accept) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata[31:0];
    end
  end

  // NOTE: the memory array has no reset; contents survive rst and a store
  // aborted by reset never reaches mem_we.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= store_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = BUS_WIDTH'(rdata_q);
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Directed load/store sequence against data_mem_responder. Each request pushes
// its expected response into a scoreboard queue; the entry is popped and
// compared when resp_valid appears. Latency, response stability under
// back-pressure, ignored requests outside IDLE and reset abort are checked too.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int BUS_WIDTH   = 32;
  localparam int DEPTH_WORDS = 256;
  localparam int WAIT_CYCLES = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  data_mem_responder #(
    .BUS_WIDTH   (BUS_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // One complete transaction. hold = cycles resp_ready stays low in RESP;
  // spam = keep req_valid high with a store of all-ones to addr while busy.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err, input string tag, input int hold,
                      input bit spam);
    exp_t e;
    int   lat;
    @(negedge clk);
    check({tag, " req_ready"}, 32'(req_ready), 32'h1);
    resp_ready = (hold == 0);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err, tag: tag});
    @(posedge clk);
    #1;
    if (spam) begin
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_wdata  = 32'hFFFF_FFFF;
    end else begin
      req_valid = 1'b0;
    end
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    req_valid = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(WAIT_CYCLES + 1));
    e = sb_q.pop_front();
    if (resp_valid === 1'b1) begin
      check({e.tag, " rdata"}, resp_rdata, e.rdata);
      check({e.tag, " err"}, 32'(resp_err), 32'(e.err));
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check({tag, " hold valid"}, 32'(resp_valid), 32'h1);
        check({tag, " hold rdata"}, resp_rdata, e.rdata);
        check({tag, " hold err"}, 32'(resp_err), 32'(e.err));
        check({tag, " hold req_ready"}, 32'(req_ready), 32'h0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      check({tag, " back to idle valid"}, 32'(resp_valid), 32'h0);
      check({tag, " back to idle ready"}, 32'(req_ready), 32'h1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset resp_valid", 32'(resp_valid), 32'h0);
    check("reset resp_rdata", resp_rdata, 32'h0);
    check("reset resp_err", 32'(resp_err), 32'h0);
    check("reset req_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    rst = 1'b1;

    // Word store / load and lane extraction
    xact(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0, "SW 0x10",  0, 1'b0);
    xact(1'b0, 3'b010, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, "LW 0x10",  0, 1'b0);
    xact(1'b0, 3'b000, 32'h13, 32'h0,         32'hFFFF_FFDE, 1'b0, "LB 0x13",  0, 1'b0);
    xact(1'b0, 3'b100, 32'h13, 32'h0,         32'h0000_00DE, 1'b0, "LBU 0x13", 0, 1'b0);
    xact(1'b0, 3'b001, 32'h12, 32'h0,         32'hFFFF_DEAD, 1'b0, "LH 0x12",  0, 1'b0);
    xact(1'b0, 3'b101, 32'h10, 32'h0,         32'h0000_BEEF, 1'b0, "LHU 0x10", 0, 1'b0);

    // Byte store merges into one lane
    xact(1'b1, 3'b000, 32'h11, 32'h0000_0055, 32'h0,         1'b0, "SB 0x11",  0, 1'b0);
    xact(1'b0, 3'b010, 32'h10, 32'h0,         32'hDEAD_55EF, 1'b0, "LW 0x10 after SB", 0, 1'b0);
    xact(1'b0, 3'b000, 32'h11, 32'h0,         32'h0000_0055, 1'b0, "LB 0x11",  0, 1'b0);

    // Rejected requests
    xact(1'b0, 3'b010, 32'h12,  32'h0,         32'h0, 1'b1, "LW 0x12 misaligned",  0, 1'b0);
    xact(1'b1, 3'b001, 32'h11,  32'h1234_5678, 32'h0, 1'b1, "SH 0x11 misaligned",  0, 1'b0);
    xact(1'b0, 3'b011, 32'h10,  32'h0,         32'h0, 1'b1, "load funct3 011",     0, 1'b0);
    xact(1'b0, 3'b010, 32'h400, 32'h0,         32'h0, 1'b1, "LW 0x400 range",      0, 1'b0);
    xact(1'b1, 3'b011, 32'h10,  32'h1111_2222, 32'h0, 1'b1, "store funct3 011",    0, 1'b0);
    xact(1'b1, 3'b100, 32'h10,  32'h1111_2222, 32'h0, 1'b1, "store funct3 100",    0, 1'b0);
    // Unchanged word, with back-pressure in RESP
    xact(1'b0, 3'b010, 32'h10,  32'h0, 32'hDEAD_55EF, 1'b0, "LW 0x10 hold", 5, 1'b0);

    // Out-of-range store must not alias onto word 0
    xact(1'b1, 3'b010, 32'h0,   32'h1111_1111, 32'h0,         1'b0, "SW 0x0",           0, 1'b0);
    xact(1'b1, 3'b010, 32'h400, 32'h2222_2222, 32'h0,         1'b1, "SW 0x400 range",   0, 1'b0);
    // Requests presented while busy are ignored
    xact(1'b0, 3'b010, 32'h0,   32'h0,         32'h1111_1111, 1'b0, "LW 0x0 busy spam", 0, 1'b1);
    xact(1'b0, 3'b010, 32'h0,   32'h0,         32'h1111_1111, 1'b0, "LW 0x0 after spam", 0, 1'b0);

    // Halfword store on the upper lane
    xact(1'b1, 3'b001, 32'h12, 32'hFFFF_ABCD, 32'h0,         1'b0, "SH 0x12",  0, 1'b0);
    xact(1'b0, 3'b010, 32'h10, 32'h0,         32'hABCD_55EF, 1'b0, "LW 0x10 after SH", 0, 1'b0);
    xact(1'b0, 3'b101, 32'h12, 32'h0,         32'h0000_ABCD, 1'b0, "LHU 0x12", 0, 1'b0);
    xact(1'b0, 3'b001, 32'h10, 32'h0,         32'h0000_55EF, 1'b0, "LH 0x10",  0, 1'b0);

    // Reset during WAIT aborts a pending store
    xact(1'b1, 3'b010, 32'h20, 32'h0000_0007, 32'h0, 1'b0, "SW 0x20 7", 0, 1'b0);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h20;
    req_wdata  = 32'h0000_0001;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("abort accepted", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort reset resp_valid", 32'(resp_valid), 32'h0);
    check("abort reset req_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("abort idle resp_valid", 32'(resp_valid), 32'h0);
      check("abort idle req_ready", 32'(req_ready), 32'h1);
    end
    xact(1'b0, 3'b010, 32'h20, 32'h0, 32'h0000_0007, 1'b0, "LW 0x20 after abort", 0, 1'b0);

    check("scoreboard empty", 32'(sb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
